pipe_stage_reg: RTL

Parametrised pipeline stage register for the RISC-V core. It replaces the fixed, always-loading inter-stage registers (IF/ID, ID/EX, EX/M, M/WB) with one generic block. Each stage carries a payload bus and a control bus, a valid/ready handshake for stalls, and a flush that turns the stage into a bubble. An optional skid entry registers `in_ready`, so long stall chains do not form a combinational ready path through the whole pipe.

---
 rtl/pipe_stage_reg.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic inter-stage pipeline register for the RISC-V core.
// Carries a payload bus and a control bus with a valid/ready handshake and
// a flush that turns the stage into a bubble. With SKID=1 a second entry
// makes in_ready come from a register, which breaks long ready chains.
//
// Ports:
//   clk, rst       rising-edge clock, synchronous active-high reset
//   in_valid       upstream offers an instruction
//   in_ready       stage accepts this cycle (0 while rst is high)
//   in_data        upstream payload, DATA_W bits
//   in_ctrl        upstream control, CTRL_W bits (all-zero means NOP)
//   flush          kill the stage contents and the input offered this cycle
//   out_valid      stage holds a valid instruction
//   out_ready      downstream accepts; 0 stalls the stage
//   out_data       registered payload (meaningless when out_valid is 0)
//   out_ctrl       registered control, forced to 0 when out_valid is 0
//   skid_full      skid entry occupied (always 0 when SKID=0)

module pipe_stage_reg #(
    parameter int DATA_W = 96,
    parameter int CTRL_W = 8,
    parameter int SKID   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic              skid_full
);

    // Main entry: the one visible on out_*.
    logic              main_valid_q;
    logic              main_valid_d;
    logic [DATA_W-1:0] main_data_q;
    logic [DATA_W-1:0] main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q;
    logic [CTRL_W-1:0] main_ctrl_d;

    // Skid entry: holds the instruction accepted while main was stalled.
    logic              skid_valid_q;
    logic              skid_valid_d;
    logic [DATA_W-1:0] skid_data_q;
    logic [DATA_W-1:0] skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q;
    logic [CTRL_W-1:0] skid_ctrl_d;

    logic in_xfer;
    logic out_xfer;
    logic main_free;

    generate
        if (SKID == 0) begin : g_noskid
            // Ready looks through the stage: a draining or flushed
            // entry frees the slot in the same cycle.
            assign in_ready  = !rst && (!main_valid_q || out_ready || flush);
            assign skid_full = 1'b0;
        end else begin : g_skid
            // Ready depends only on flop state, so no path runs from
            // out_ready to in_ready. rst gating keeps it low in reset.
            assign in_ready  = !rst && !skid_valid_q;
            assign skid_full = skid_valid_q;
        end
    endgenerate

    assign out_valid = main_valid_q;
    assign out_data  = main_data_q;
    assign out_ctrl  = main_ctrl_q;

    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        main_ctrl_d  = main_ctrl_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_ctrl_d  = skid_ctrl_q;

        in_xfer   = in_valid && in_ready;
        out_xfer  = main_valid_q && out_ready;
        // Main can take a new entry when empty or being drained now.
        main_free = !main_valid_q || out_xfer;

        if (flush) begin
            // Current output may still transfer this cycle; only the
            // next state becomes a bubble. Data is left as-is.
            main_valid_d = 1'b0;
            main_ctrl_d  = '0;
            skid_valid_d = 1'b0;
            skid_ctrl_d  = '0;
        end else if (main_free) begin
            if (skid_valid_q) begin
                // Skid is older than any input, so it goes first.
                // in_ready is 0 here, so no input is lost.
                main_valid_d = 1'b1;
                main_data_d  = skid_data_q;
                main_ctrl_d  = skid_ctrl_q;
                skid_valid_d = 1'b0;
                skid_ctrl_d  = '0;
            end else if (in_xfer) begin
                main_valid_d = 1'b1;
                main_data_d  = in_data;
                main_ctrl_d  = in_ctrl;
            end else begin
                main_valid_d = 1'b0;
                main_ctrl_d  = '0;
            end
        end else if (in_xfer) begin
            // Main is stalled; only reachable with the skid entry,
            // since without it in_ready is low in this state.
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
            skid_ctrl_d  = in_ctrl;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            main_ctrl_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_ctrl_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            main_ctrl_q  <= main_ctrl_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_ctrl_q  <= skid_ctrl_d;
        end
    end

endmodule
